// File: rtl/letc_core_limp_arbiter.sv
// rtl/letc_core_limp_arbiter.sv - N-to-1 LIMP request arbiter with registered, locked grant.
// Optional: LETC_CORE_LIMP_ARB_FIXED_PRIO_EN selects fixed priority (channel 0 highest) instead of round-robin.
module letc_core_limp_arbiter #(
    parameter int NUM_CH = 3,
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int IDXW   = $clog2(NUM_CH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_CH-1:0]    i_req_valid,
    output logic [NUM_CH-1:0]    o_req_ready,
    input  logic [NUM_CH-1:0]    i_req_wen_nren,
    input  logic [NUM_CH*2-1:0]  i_req_size,
    input  logic [NUM_CH*AW-1:0] i_req_addr,
    input  logic [NUM_CH*DW-1:0] i_req_wdata,
    output logic [DW-1:0]        o_req_rdata,
    output logic [IDXW-1:0]      o_grant_idx,
    output logic                 o_busy,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_wen_nren,
    output logic [1:0]           o_size,
    output logic [AW-1:0]        o_addr,
    output logic [DW-1:0]        o_wdata,
    input  logic [DW-1:0]        i_rdata
);

    generate
        if (NUM_CH < 2) begin : g_bad_num_ch
            $error("letc_core_limp_arbiter: NUM_CH must be >= 2");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t          r_state;
    logic [IDXW-1:0] r_grant;
`ifndef LETC_CORE_LIMP_ARB_FIXED_PRIO_EN
    logic [IDXW-1:0] r_last;
`endif

    logic [1:0]      w_size_ch  [NUM_CH];
    logic [AW-1:0]   w_addr_ch  [NUM_CH];
    logic [DW-1:0]   w_wdata_ch [NUM_CH];
    logic [IDXW-1:0] w_winner;
    logic [IDXW-1:0] w_lo;
    logic [IDXW-1:0] w_hi;
    logic            w_hi_found;
    logic            w_any;
    logic            w_in_busy;
    logic            w_sel_valid;
    logic            w_complete;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_split
        assign w_size_ch[c]  = i_req_size[2*c +: 2];
        assign w_addr_ch[c]  = i_req_addr[AW*c +: AW];
        assign w_wdata_ch[c] = i_req_wdata[DW*c +: DW];
    end

    // w_lo is the lowest valid channel; w_hi the lowest valid channel above the last grant.
    always_comb begin
        w_lo       = '0;
        w_hi       = '0;
        w_hi_found = 1'b0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (i_req_valid[c]) begin
                w_lo = IDXW'(c);
`ifndef LETC_CORE_LIMP_ARB_FIXED_PRIO_EN
                if (IDXW'(c) > r_last) begin
                    w_hi       = IDXW'(c);
                    w_hi_found = 1'b1;
                end
`endif
            end
        end
    end

`ifdef LETC_CORE_LIMP_ARB_FIXED_PRIO_EN
    assign w_winner = w_lo;
`else
    assign w_winner = w_hi_found ? w_hi : w_lo;
`endif

    assign w_any       = |i_req_valid;
    assign w_in_busy   = (r_state == ST_BUSY);
    assign w_sel_valid = i_req_valid[r_grant];
    assign w_complete  = o_valid && i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
`ifndef LETC_CORE_LIMP_ARB_FIXED_PRIO_EN
            r_last  <= IDXW'(NUM_CH - 1);
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_winner;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_complete) begin
`ifndef LETC_CORE_LIMP_ARB_FIXED_PRIO_EN
                        r_last  <= r_grant;
`endif
                        r_state <= ST_IDLE;
                    end else if (!w_sel_valid) begin
                        // Requester abandoned its transaction: drop it without touching fairness state.
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_valid     = w_in_busy && w_sel_valid;
    assign o_busy      = w_in_busy;
    assign o_grant_idx = r_grant;
    assign o_wen_nren  = w_in_busy && i_req_wen_nren[r_grant];
    assign o_size      = w_in_busy ? w_size_ch[r_grant]  : 2'b00;
    assign o_addr      = w_in_busy ? w_addr_ch[r_grant]  : '0;
    assign o_wdata     = w_in_busy ? w_wdata_ch[r_grant] : '0;
    assign o_req_rdata = w_complete ? i_rdata : '0;

    always_comb begin
        o_req_ready = '0;
        if (w_complete) begin
            o_req_ready[r_grant] = 1'b1;
        end
    end

`ifndef SYNTHESIS
    a_no_abandon: assert property (@(posedge i_clk) disable iff (i_rst)
        w_in_busy |-> w_sel_valid);
`endif

endmodule

// File: tb/tb_letc_core_limp_arbiter.sv
// tb/tb_letc_core_limp_arbiter.sv - self-checking bench for letc_core_limp_arbiter (NUM_CH=3).
module tb_letc_core_limp_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_wen;
    logic [N*2-1:0]  req_size;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   req_rdata;
    logic [1:0]      grant_idx;
    logic            busy;
    logic            dvalid;
    logic            dready;
    logic            dwen;
    logic [1:0]      dsize;
    logic [AW-1:0]   daddr;
    logic [DW-1:0]   dwdata;
    logic [DW-1:0]   drdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    letc_core_limp_arbiter #(.NUM_CH(N), .AW(AW), .DW(DW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_wen_nren(req_wen), .i_req_size(req_size),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_req_rdata(req_rdata), .o_grant_idx(grant_idx), .o_busy(busy),
        .o_valid(dvalid), .i_ready(dready), .o_wen_nren(dwen),
        .o_size(dsize), .o_addr(daddr), .o_wdata(dwdata), .i_rdata(drdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_wen = '0; req_size = '0;
        req_addr = '0; req_wdata = '0; dready = 1'b0; drdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Reference pick: round-robin is "nearest valid channel after the last grant".
    function automatic int ref_pick(input logic [N-1:0] v, input int last);
        int best;
        int bd;
        best = -1;
        bd   = N;
        for (int c = 0; c < N; c++) begin
            if (v[c]) begin
`ifdef LETC_CORE_LIMP_ARB_FIXED_PRIO_EN
                if (best < 0) best = c;
`else
                if (((c - last - 1 + 2*N) % N) < bd) begin
                    bd   = (c - last - 1 + 2*N) % N;
                    best = c;
                end
`endif
            end
        end
        return best;
    endfunction

    typedef struct {
        logic [N-1:0] v;
        logic         rdy;
        logic         ev;
        logic [1:0]   eg;
        logic [N-1:0] er;
        logic         eb;
    } vec_t;

    vec_t tbl[10];

    logic          m_busy;
    int            m_grant;
    int            m_last;
    logic [N-1:0]  r_pend;
    logic [AW-1:0] r_addr [N];
    logic [DW-1:0] r_wdata[N];
    logic          r_wen  [N];
    logic [1:0]    r_size [N];
    logic          e_valid;
    logic [N-1:0]  e_ready;

    initial begin
        rst = 1'b1;
        clear_inputs();

`ifndef LETC_CORE_LIMP_ARB_FIXED_PRIO_EN
        // Round-robin with all channels continuously valid and downstream always ready.
        tbl[0] = '{3'b111, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0};
        tbl[1] = '{3'b111, 1'b1, 1'b1, 2'd0, 3'b001, 1'b1};
        tbl[2] = '{3'b111, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0};
        tbl[3] = '{3'b111, 1'b1, 1'b1, 2'd1, 3'b010, 1'b1};
        tbl[4] = '{3'b111, 1'b1, 1'b0, 2'd1, 3'b000, 1'b0};
        tbl[5] = '{3'b111, 1'b1, 1'b1, 2'd2, 3'b100, 1'b1};
        tbl[6] = '{3'b111, 1'b1, 1'b0, 2'd2, 3'b000, 1'b0};
        tbl[7] = '{3'b111, 1'b1, 1'b1, 2'd0, 3'b001, 1'b1};
        tbl[8] = '{3'b111, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0};
        tbl[9] = '{3'b111, 1'b1, 1'b1, 2'd1, 3'b010, 1'b1};
        do_reset();
        chk("reset_valid", dvalid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_grant", grant_idx, 0);
        chk("reset_ready", req_ready, 0);
        chk("reset_addr", daddr, 0);
        for (int c = 0; c < N; c++) req_addr[AW*c +: AW] = 32'h1000 + c;
        for (int i = 0; i < 10; i++) begin
            req_valid = tbl[i].v;
            dready    = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d_valid", i), dvalid, tbl[i].ev);
            chk($sformatf("tbl%0d_grant", i), grant_idx, tbl[i].eg);
            chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].er);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
            chk($sformatf("tbl%0d_addr", i), daddr, tbl[i].eb ? 32'h1000 + tbl[i].eg : 32'h0);
            step();
        end
`else
        // Fixed priority: ch0 and ch2 continuously valid, ch2 must never win.
        do_reset();
        req_valid = 3'b101;
        dready    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (busy) chk($sformatf("fp%0d_grant", i), grant_idx, 0);
            chk($sformatf("fp%0d_ready", i), req_ready, busy ? 3'b001 : 3'b000);
            step();
        end
`endif

        // Single read on ch1 with downstream completing two cycles after o_valid.
        do_reset();
        req_valid = 3'b010;
        req_addr[AW*1 +: AW] = 32'h8000_0010;
        #1;
        chk("rd_arb_valid", dvalid, 0);
        step();
        chk("rd_valid", dvalid, 1);
        chk("rd_grant", grant_idx, 1);
        chk("rd_addr", daddr, 32'h8000_0010);
        chk("rd_wen", dwen, 0);
        chk("rd_wait_ready", req_ready, 0);
        step();
        chk("rd_wait2_ready", req_ready, 0);
        step();
        dready = 1'b1;
        drdata = 32'hDEAD_BEEF;
        #1;
        chk("rd_ready", req_ready, 3'b010);
        chk("rd_rdata", req_rdata, 32'hDEAD_BEEF);
        step();
        req_valid = 3'b000;
        dready    = 1'b0;
        #1;
        chk("rd_after_ready", req_ready, 0);
        chk("rd_after_busy", busy, 0);

        // Grant lock: ch2 holds the grant while ch0 raises valid.
        do_reset();
        req_valid = 3'b100;
        step();
        chk("lock_grant", grant_idx, 2);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) req_valid = 3'b101;
            #1;
            chk($sformatf("lock%0d_grant", i), grant_idx, 2);
            chk($sformatf("lock%0d_ready", i), req_ready, 0);
            step();
        end
        dready = 1'b1;
        #1;
        chk("lock_done_ready", req_ready, 3'b100);
        step();
        req_valid = 3'b001;
        dready    = 1'b0;
        step();
        chk("lock_next_grant", grant_idx, 0);
        chk("lock_next_busy", busy, 1);

        // Write pass-through on ch0.
        do_reset();
        req_valid = 3'b001;
        req_wen   = 3'b001;
        req_size[1:0]   = 2'b10;
        req_wdata[31:0] = 32'h1234_5678;
        step();
        chk("wr_wen", dwen, 1);
        chk("wr_size", dsize, 2'b10);
        chk("wr_wdata", dwdata, 32'h1234_5678);
        dready = 1'b1;
        #1;
        chk("wr_ready", req_ready, 3'b001);
        step();
        clear_inputs();

        // Asynchronous reset while ch1 is mid-transaction.
        do_reset();
        req_valid = 3'b010;
        step();
        dready = 1'b1;
        #1;
        chk("rst_mid_pre_ready", req_ready, 3'b010);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", dvalid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", req_ready, 0);
        step();
        rst       = 1'b0;
        dready    = 1'b0;
        req_valid = 3'b011;
        step();
        chk("rst_after_grant", grant_idx, 0);
        chk("rst_after_busy", busy, 1);

        // Randomised traffic against the transaction-level reference model.
        do_reset();
        m_busy = 1'b0; m_grant = 0; m_last = N - 1;
        r_pend = '0;
        for (int c = 0; c < N; c++) begin
            r_addr[c] = '0; r_wdata[c] = '0; r_wen[c] = 1'b0; r_size[c] = 2'b00;
        end
        for (int cyc = 0; cyc < 800; cyc++) begin
            req_valid = r_pend;
            for (int c = 0; c < N; c++) begin
                req_wen[c]              = r_wen[c];
                req_size[2*c +: 2]      = r_size[c];
                req_addr[AW*c +: AW]    = r_addr[c];
                req_wdata[DW*c +: DW]   = r_wdata[c];
            end
            dready = ($urandom_range(0, 2) != 0);
            drdata = $urandom;
            #3;
            e_valid = m_busy && r_pend[m_grant];
            e_ready = (e_valid && dready) ? N'(1 << m_grant) : '0;
            chk("rnd_valid", dvalid, e_valid);
            chk("rnd_busy", busy, m_busy);
            chk("rnd_grant", grant_idx, m_grant);
            chk("rnd_ready", req_ready, e_ready);
            chk("rnd_addr", daddr, m_busy ? r_addr[m_grant] : 32'h0);
            chk("rnd_wdata", dwdata, m_busy ? r_wdata[m_grant] : 32'h0);
            chk("rnd_wen", dwen, m_busy ? r_wen[m_grant] : 1'b0);
            chk("rnd_rdata", req_rdata, (e_ready != 0) ? drdata : 32'h0);
            if (!m_busy) begin
                if (r_pend != 0) begin
                    m_busy  = 1'b1;
                    m_grant = ref_pick(r_pend, m_last);
                end
            end else if (e_valid && dready) begin
                m_last = m_grant;
                m_busy = 1'b0;
            end
            for (int c = 0; c < N; c++) begin
                if (e_ready[c]) r_pend[c] = 1'b0;
                if (!r_pend[c] && ($urandom_range(0, 1) == 1)) begin
                    r_pend[c]  = 1'b1;
                    r_addr[c]  = $urandom;
                    r_wdata[c] = $urandom;
                    r_wen[c]   = 1'($urandom_range(0, 1));
                    r_size[c]  = 2'($urandom_range(0, 2));
                end
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
